dot_product_engine: RTL and testbench



---
 rtl/dot_product_engine.sv | 156 +++++++++++++++
 tb/tb_dot_product_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_engine.sv
// Streaming dot-product engine: LANES multiplies per beat, lane reduction into a
// registered stage, accumulation over BEATS beats, then wrap/saturate result formation.
module dot_product_engine #(
  parameter int FEATURE_WIDTH  = 5,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int VECTOR_LEN     = 96,
  parameter int LANES          = 12
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [0:LANES-1][FEATURE_WIDTH-1:0]     feature_chunk,
  input  logic [0:LANES-1][FEATURE_WIDTH-1:0]     weight_chunk,
  input  logic                                    sat_en,
  input  logic                                    sync_clr,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DOT_PROD_WIDTH-1:0]               dot_out,
  output logic                                    overflow,
  output logic [1:0]                              dbg_state
);

  localparam int BEATS     = VECTOR_LEN / LANES;
  localparam int ACC_WIDTH = 2*FEATURE_WIDTH + $clog2(VECTOR_LEN);
  localparam int PROD_W    = 2*FEATURE_WIDTH;
  localparam int SUM_W     = PROD_W + $clog2(LANES);
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EXT_W     = ((ACC_WIDTH > DOT_PROD_WIDTH) ? ACC_WIDTH : DOT_PROD_WIDTH) + 1;

  // Handshakes: a beat moves on a rising edge with in_valid && in_ready, a result
  // moves with out_valid && out_ready; sync_clr overrides both in the same cycle.
  typedef enum logic [1:0] {ACCUM = 2'd0, FLUSH = 2'd1, OUT = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [SUM_W-1:0]      s1_sum_q, s1_sum_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_last_q, s1_last_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  out_valid_q, out_valid_d;
  logic [DOT_PROD_WIDTH-1:0] dot_q, dot_d;
  logic                  ovf_q, ovf_d;

  logic [PROD_W-1:0]     prod [LANES];
  logic [SUM_W-1:0]      lane_sum;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic [EXT_W-1:0]      final_ext;
  logic                  accept, last_beat, out_hs, load_result, final_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sync_clr) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && last_beat) state_d = FLUSH;
        FLUSH:   state_d = OUT;
        OUT:     if (out_hs) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    dbg_state = state_q;
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i]  = PROD_W'(feature_chunk[i]) * PROD_W'(weight_chunk[i]);
      lane_sum = lane_sum + SUM_W'(prod[i]);
    end
  end

  // The final sum is formed from the accumulator plus the last beat still in stage 1.
  always_comb begin
    accept      = in_valid && in_ready && !sync_clr;
    last_beat   = (beat_cnt_q == CNT_W'(BEATS - 1));
    out_hs      = out_valid_q && out_ready;
    acc_sum     = acc_q + ACC_WIDTH'(s1_sum_q);
    final_ext   = EXT_W'(acc_sum);
    final_ovf   = final_ext > EXT_W'({DOT_PROD_WIDTH{1'b1}});
    load_result = (state_q == FLUSH) && s1_valid_q && s1_last_q && !sync_clr;
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    s1_sum_d    = s1_sum_q;
    s1_valid_d  = accept;
    s1_last_d   = accept && last_beat;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    dot_d       = dot_q;
    ovf_d       = ovf_q;
    if (accept) begin
      s1_sum_d   = lane_sum;
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    end
    if (s1_valid_q) acc_d = acc_sum;
    if (state_q == OUT && out_hs) begin
      acc_d       = '0;
      out_valid_d = 1'b0;
    end
    if (load_result) begin
      out_valid_d = 1'b1;
      ovf_d       = final_ovf;
      dot_d       = (sat_en && final_ovf) ? {DOT_PROD_WIDTH{1'b1}}
                                          : final_ext[DOT_PROD_WIDTH-1:0];
    end
    if (sync_clr) begin
      beat_cnt_d  = '0;
      acc_d       = '0;
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      s1_sum_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dot_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      s1_sum_q    <= s1_sum_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      dot_q       <= dot_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dot_out   = dot_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine: expected {overflow, dot_out} pairs are
// queued by the stimulus and checked by an independent output monitor.
module tb_dot_product_engine;

  localparam int FW    = 5;
  localparam int DW    = 16;
  localparam int VL    = 96;
  localparam int LN    = 12;
  localparam int NBEAT = VL / LN;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [0:LN-1][FW-1:0]       feature_chunk = '0;
  logic [0:LN-1][FW-1:0]       weight_chunk = '0;
  logic                        sat_en = 1'b0;
  logic                        sync_clr = 1'b0;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic [DW-1:0]               dot_out;
  logic                        overflow;
  logic [1:0]                  dbg_state;

  logic [DW:0]   exp_q[$];
  logic [FW-1:0] fvec [VL];
  logic [FW-1:0] wvec [VL];
  int n_cmp = 0;
  int n_err = 0;

  dot_product_engine #(
    .FEATURE_WIDTH(FW), .DOT_PROD_WIDTH(DW), .VECTOR_LEN(VL), .LANES(LN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .feature_chunk(feature_chunk), .weight_chunk(weight_chunk),
    .sat_en(sat_en), .sync_clr(sync_clr), .out_valid(out_valid),
    .out_ready(out_ready), .dot_out(dot_out), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill(input logic [FW-1:0] f, input logic [FW-1:0] w);
    for (int k = 0; k < VL; k++) begin
      fvec[k] = f;
      wvec[k] = w;
    end
  endtask

  // Presents beat b until it is accepted; returns just after the accepting edge.
  task automatic drive_beat(input int b);
    int t;
    t = 0;
    for (int l = 0; l < LN; l++) begin
      feature_chunk[l] = fvec[b*LN + l];
      weight_chunk[l]  = wvec[b*LN + l];
    end
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("beat_accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vector(input int max_bubble);
    for (int b = 0; b < NBEAT; b++) begin
      repeat ($urandom_range(0, max_bubble)) begin
        @(posedge clk);
        #1;
      end
      drive_beat(b);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    #1;
  endtask

  // Output monitor: one comparison per output handshake.
  initial begin
    logic [DW:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !sync_clr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {15'd0, overflow, dot_out}, 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("result", {15'd0, overflow, dot_out}, {15'd0, exp});
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] held_dot;
    logic          held_ovf;
    int t;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dot_out", 32'(dot_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All ones: 96, with latency and immediate re-accept
    fill(5'd1, 5'd1);
    exp_q.push_back({1'b0, 16'd96});
    send_vector(0);
    @(negedge clk);
    check("flush_no_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("out_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("reaccept_in_ready", 32'(in_ready), 32'd1);
    check("out_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    wait_drain();

    // All 31: 92256 wraps to 26720; saturated to 65535
    fill(5'd31, 5'd31);
    sat_en = 1'b0;
    exp_q.push_back({1'b1, 16'd26720});
    send_vector(0);
    wait_drain();
    sat_en = 1'b1;
    exp_q.push_back({1'b1, 16'd65535});
    send_vector(0);
    wait_drain();
    sat_en = 1'b0;

    // Ramp k mod 32 times 1: 1488, without and with bubbles
    for (int k = 0; k < VL; k++) begin
      fvec[k] = FW'(k % 32);
      wvec[k] = 5'd1;
    end
    exp_q.push_back({1'b0, 16'd1488});
    send_vector(0);
    wait_drain();
    exp_q.push_back({1'b0, 16'd1488});
    send_vector(3);
    wait_drain();

    // Backpressure: result held, in_ready low, presented beats ignored
    out_ready = 1'b0;
    fill(5'd1, 5'd1);
    exp_q.push_back({1'b0, 16'd96});
    send_vector(0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("stall_out_valid_seen", 32'(out_valid), 32'd1);
    held_dot = dot_out;
    held_ovf = overflow;
    check("stall_dot_value", 32'(held_dot), 32'd96);
    fill(5'd31, 5'd31);
    for (int l = 0; l < LN; l++) begin
      feature_chunk[l] = 5'd31;
      weight_chunk[l]  = 5'd31;
    end
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_dot", 32'(dot_out), 32'(held_dot));
      check("stall_ovf", 32'(overflow), 32'(held_ovf));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    wait_drain();
    fill(5'd1, 5'd1);
    exp_q.push_back({1'b0, 16'd96});
    send_vector(0);
    wait_drain();

    // sync_clr aborts a partial vector of 31s
    fill(5'd31, 5'd31);
    for (int b = 0; b < 3; b++) drive_beat(b);
    sync_clr = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    fill(5'd1, 5'd1);
    exp_q.push_back({1'b0, 16'd96});
    send_vector(0);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset after beat 5
    fill(5'd31, 5'd31);
    for (int b = 0; b < 5; b++) drive_beat(b);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_dot_out", 32'(dot_out), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill(5'd1, 5'd1);
    exp_q.push_back({1'b0, 16'd96});
    send_vector(1);
    wait_drain();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
